// File: rtl/program_sequencer.sv
// program_sequencer: steps a synchronous program ROM, hands each instruction to
// the SCU with a one-cycle scu_run pulse, and waits for scu_done before advancing.
// Optional feature: define SEQ_TIMEOUT_EN to add a Done-wait watchdog that halts
// the sequencer and raises a sticky Timeout flag after TIMEOUT cycles in WAIT.
module program_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int LAST_ADDR = 31,
  parameter int TIMEOUT   = 255
) (
  input  logic              Pclk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              scu_run,
  input  logic              scu_done,
  output logic              Busy,
  output logic              Halted,
  output logic              Timeout
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_WAIT  = 3'd4,
    S_ADV   = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              stop_q, stop_d;
  logic              busy;
  logic              at_last;
  logic [ADDR_W-1:0] pc_inc;
  logic              to_hit;   // watchdog expiry in the current WAIT cycle

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign at_last = (pc_q == LAST_PC);
  // Wrap to 0 after the final address; when LAST_PC is all-ones this is also
  // the natural modulo-2^ADDR_W rollover.
  assign pc_inc  = at_last ? '0 : pc_q + 1'b1;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The count includes the current WAIT cycle, so the compare uses TIMEOUT-1
  // on the register: the TIMEOUT-th WAIT cycle without Done ends in HALT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  assign to_hit = (state_q == S_WAIT) && !scu_done && (cnt_q == CNT_LAST);

  // Watchdog next state: counter runs only in WAIT (zero on entry), flag is
  // sticky until a restart from HALT.
  always_comb begin
    cnt_d = '0;
    to_d  = to_q;
    if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    if (to_hit)                            to_d = 1'b1;
    else if ((state_q == S_HALT) && Start) to_d = 1'b0;
  end

  // Watchdog registers.
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign Timeout = to_q;
`else
  assign to_hit  = 1'b0;
  assign Timeout = 1'b0;
`endif

  // Next-state, pc and instruction-register logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        // Resume from the current pc.
        if (Start) state_d = S_FETCH;
      end
      S_HALT: begin
        // Restart the program from the top.
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        instr_d = rom_data;
        state_d = S_RUN;
      end
      S_RUN:  state_d = S_WAIT;
      S_WAIT: begin
        if (scu_done)    state_d = S_ADV;
        else if (to_hit) state_d = S_HALT;
      end
      S_ADV: begin
        if (stop_q) begin
          state_d = S_IDLE;
          pc_d    = pc_inc;
        end else if (at_last) begin
          if (Loop) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stop request latch: set by Stop while busy, cleared as we drop into IDLE.
  always_comb begin
    stop_d = stop_q;
    if ((state_q == S_ADV) && (state_d == S_IDLE)) stop_d = 1'b0;
    else if (busy && Stop)                         stop_d = 1'b1;
  end

  // Main sequencer registers.
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      stop_q  <= stop_d;
    end
  end

  assign rom_addr = pc_q;
  assign instr    = instr_q;
  assign scu_run  = (state_q == S_RUN);
  assign Busy     = busy;
  assign Halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: synchronous ROM returning 0x1000+addr, SCU
// handshake driven from the stimulus, and a transaction-level model of the
// program counter / run state checked at every launch and stop.
module tb_program_sequencer;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int LAST   = 3;
  localparam int TO     = 8;
  localparam int O_RUN  = 0;
  localparam int O_IDLE = 1;
  localparam int O_HALT = 2;

  logic              Pclk = 1'b0;
  logic              Reset, Start, Stop, Loop, scu_done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, instr;
  logic              scu_run, Busy, Halted, Timeout;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: expected pc, whether the last stop was a HALT, pending stop.
  int m_pc     = 0;
  bit m_halted = 0;
  bit m_stop   = 0;

  always #5 Pclk = ~Pclk;

  always @(posedge Pclk) rom_data <= 16'h1000 + 16'(rom_addr);

  program_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST), .TIMEOUT(TO)
  ) dut (
    .Pclk(Pclk), .Reset(Reset), .Start(Start), .Stop(Stop), .Loop(Loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr),
    .scu_run(scu_run), .scu_done(scu_done),
    .Busy(Busy), .Halted(Halted), .Timeout(Timeout)
  );

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse Start (from IDLE/HALT) or scu_done (from WAIT), advance the model,
  // then check either the next launch (latency, instr, address) or the stop state.
  task automatic fire(input bit is_start, input bit noise, output int outc);
    int n;
    int exp_lat;
    if (is_start) begin
      if (m_halted) m_pc = 0;
      m_halted = 0;
      m_stop   = 0;
      outc     = O_RUN;
      exp_lat  = 3;
    end else begin
      exp_lat = 4;
      if (m_stop) begin
        m_pc   = (m_pc == LAST) ? 0 : m_pc + 1;
        m_stop = 0;
        outc   = O_IDLE;
      end else if (m_pc == LAST) begin
        if (Loop) begin m_pc = 0; outc = O_RUN; end
        else outc = O_HALT;
      end else begin
        m_pc = m_pc + 1;
        outc = O_RUN;
      end
    end
    if (is_start) Start = 1'b1; else scu_done = 1'b1;
    tick();
    Start = 1'b0; scu_done = 1'b0; Stop = 1'b0;
    n = 1;
    if (outc == O_RUN) begin
      while (scu_run !== 1'b1 && n < 12) begin
        if (noise) begin
          scu_done = 1'($urandom);
          Start    = 1'($urandom);
        end
        tick();
        n++;
      end
      scu_done = 1'b0; Start = 1'b0;
      check("run_latency", n, exp_lat);
      check("instr", instr, 32'h1000 + m_pc);
      check("rom_addr_run", rom_addr, m_pc);
      check("busy_run", Busy, 1);
      check("halted_run", Halted, 0);
      check("timeout_run", Timeout, 0);
    end else begin
      tick();
      check("halted_end", Halted, (outc == O_HALT) ? 1 : 0);
      check("busy_end", Busy, 0);
      check("rom_addr_end", rom_addr, m_pc);
      check("scu_run_end", scu_run, 0);
      m_halted = (outc == O_HALT);
    end
  endtask

  // From the RUN cycle: spend dly cycles before Done is offered; optionally
  // raise Stop in the first WAIT cycle. Start is toggled randomly (must be ignored).
  task automatic wait_done(input int dly, input bit stop);
    for (int i = 0; i < dly; i++) begin
      tick();
      if (i == 0) begin
        check("run_one_cycle", scu_run, 0);
        check("busy_wait", Busy, 1);
        if (stop) begin Stop = 1'b1; m_stop = 1; end
      end
      Start = 1'($urandom);
    end
    Start = 1'b0;
  endtask

  initial begin
    int  o;
    bit  running;
    bit  seen;
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Loop = 1'b0; scu_done = 1'b0;
    #2;
    // Reset state before any clock edge.
    check("rst_rom_addr", rom_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_scu_run", scu_run, 0);
    check("rst_busy", Busy, 0);
    check("rst_halted", Halted, 0);
    check("rst_timeout", Timeout, 0);
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Straight run, Loop=0: 1000..1003 then HALT at address 3.
    fire(1, 0, o);
    for (int k = 0; k < 4; k++) begin
      wait_done(2, 0);
      fire(0, 0, o);
    end
    check("halt_rom_addr", rom_addr, 3);

    // Start from HALT restarts at 0; then Loop=1 wraps 1003 -> 1000.
    fire(1, 0, o);
    Loop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(2, 0);
      fire(0, 0, o);
    end
    check("loop_wrap_addr", rom_addr, 0);

    // Stop during WAIT of address 1 -> IDLE at 2, resume gives 1002.
    wait_done(2, 0);
    fire(0, 0, o);
    Loop = 1'b0;
    wait_done(2, 1);
    fire(0, 0, o);
    check("stop_idle_addr", rom_addr, 2);
    fire(1, 0, o);
    check("resume_instr", instr, 32'h1002);
    wait_done(2, 0);
    fire(0, 0, o);
    wait_done(2, 0);
    fire(0, 0, o);

    // Reset asserted mid-WAIT with a stop latched: all outputs drop at once,
    // and a later Done launches nothing.
    fire(1, 0, o);
    tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    Reset = 1'b1;
    #1;
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_scu_run", scu_run, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_halted", Halted, 0);
    check("mid_rst_timeout", Timeout, 0);
    tick();
    Reset = 1'b0;
    m_pc = 0; m_halted = 0; m_stop = 0;
    scu_done = 1'b1;
    tick();
    scu_done = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (scu_run === 1'b1) seen = 1;
    end
    check("no_run_after_reset", seen, 0);
    check("idle_after_reset", Busy, 0);

    // The stop latched before reset must be gone: this run continues past 0.
    fire(1, 0, o);
    wait_done(2, 0);
    fire(0, 0, o);
    check("stop_cleared_by_reset", rom_addr, 1);

`ifdef SEQ_TIMEOUT_EN
    // SCU never answers: HALT + Timeout after the 8th WAIT cycle.
    for (int k = 0; k < TO; k++) tick();
    check("to_not_yet_halted", Halted, 0);
    check("to_not_yet_flag", Timeout, 0);
    tick();
    check("to_halted", Halted, 1);
    check("to_flag", Timeout, 1);
    check("to_busy", Busy, 0);
    m_halted = 1;
    fire(1, 0, o);
    check("to_cleared", Timeout, 0);
`else
    // Without the watchdog WAIT holds indefinitely.
    for (int k = 0; k < 300; k++) tick();
    check("long_wait_busy", Busy, 1);
    check("long_wait_halted", Halted, 0);
    check("long_wait_timeout", Timeout, 0);
    fire(0, 0, o);
`endif

    // Randomized phase: random Done delays, Loop, Stop and Start noise.
    running = 1;
    for (int k = 0; k < 120; k++) begin
      if (running) begin
        wait_done($urandom_range(1, 5), ($urandom % 6) == 0);
        Loop = 1'($urandom);
        fire(0, 1, o);
      end else begin
        fire(1, 1, o);
      end
      running = (o == O_RUN);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
